// File: rtl/alpha_col_feeder_if.sv
// rtl/alpha_col_feeder_if.sv - stream bundle between the alpha/H sources, the column feeder and the core
//
// Purpose: groups every handshake, data and status signal of the alpha column
// feeder so the block exposes one bus port next to clk/rst.
// Ports (signals):
//   s_alpha/_tvalid/_tready     alpha element stream, column-major k = a*J + j
//   s_h_row/s_h_tvalid/_tready  parity-check row for the frame
//   core_done                   one-cycle pulse, core finished the frame
//   H_row/H_row_tvalid          row to the core, one beat per frame
//   alpha_u_col/_tvalid/_tlast  one J-element column per beat, no backpressure
//   frames_sent                 frames fully emitted, 16-bit wrapping
// Modports: slave = feeder view, master = source/core view.
interface alpha_col_feeder_if #(
  parameter int J         = 14,
  parameter int DATAWIDTH = 8
);
  logic [DATAWIDTH-1:0]   s_alpha;
  logic                   s_alpha_tvalid;
  logic                   s_alpha_tready;
  logic [J-1:0]           s_h_row;
  logic                   s_h_tvalid;
  logic                   s_h_tready;
  logic                   core_done;
  logic [J-1:0]           H_row;
  logic                   H_row_tvalid;
  logic [J*DATAWIDTH-1:0] alpha_u_col;
  logic                   alpha_u_col_tvalid;
  logic                   alpha_u_col_tlast;
  logic [15:0]            frames_sent;

  modport slave (
    input  s_alpha, s_alpha_tvalid, s_h_row, s_h_tvalid, core_done,
    output s_alpha_tready, s_h_tready, H_row, H_row_tvalid,
           alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast, frames_sent
  );

  modport master (
    output s_alpha, s_alpha_tvalid, s_h_row, s_h_tvalid, core_done,
    input  s_alpha_tready, s_h_tready, H_row, H_row_tvalid,
           alpha_u_col, alpha_u_col_tvalid, alpha_u_col_tlast, frames_sent
  );
endinterface

// File: rtl/alpha_col_feeder.sv
// rtl/alpha_col_feeder.sv - buffers one frame of alpha elements plus an H row, then feeds the core column by column
//
// Purpose: collects J*A alpha elements (column-major) and one H row, emits the
// row for one cycle, then A consecutive columns of J elements, and waits for
// the core's done pulse before accepting the next frame.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  alpha_col_feeder_if.slave (alpha/H inputs, core_done, H_row,
//        alpha_u_col stream and frames_sent counter)
module alpha_col_feeder #(
  parameter int J         = 14,
  parameter int A         = 2,
  parameter int DATAWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  alpha_col_feeder_if.slave   bus
);

  localparam int NK = J * A;
  localparam int KW = $clog2(NK + 1);
  localparam int AW = (A > 1) ? $clog2(A) : 1;
  localparam logic [KW-1:0] K_FULL = KW'(NK);
  localparam logic [KW-1:0] K_LAST = KW'(NK - 1);
  localparam logic [AW-1:0] A_LAST = AW'(A - 1);

  typedef enum logic [1:0] {LOAD, SEND_H, SEND_A, WAIT_DONE} state_t;

  state_t                 state, state_next;
  logic [KW-1:0]          k;
  logic [AW-1:0]          a;
  logic                   h_held;
  logic [J-1:0]           h_reg;
  logic [15:0]            frames_cnt;
  logic [DATAWIDTH-1:0]   buffer [NK];

  logic                   alpha_ready, h_ready;
  logic                   alpha_fire, h_fire;
  logic                   last_col;
  logic [J-1:0]           h_row_out;
  logic                   h_row_valid;
  logic [J*DATAWIDTH-1:0] col_out;
  logic                   col_valid;

  always_comb begin
    state_next  = state;
    alpha_ready = 1'b0;
    h_ready     = 1'b0;
    alpha_fire  = 1'b0;
    h_fire      = 1'b0;
    last_col    = 1'b0;
    h_row_out   = '0;
    h_row_valid = 1'b0;
    col_out     = '0;
    col_valid   = 1'b0;
    case (state)
      LOAD: begin
        alpha_ready = (k != K_FULL);
        h_ready     = !h_held;
        alpha_fire  = bus.s_alpha_tvalid & alpha_ready;
        h_fire      = bus.s_h_tvalid & h_ready;
        // Look through this cycle's transfers so SEND_H follows the final beat directly.
        if (((k == K_FULL) || (alpha_fire && (k == K_LAST))) && (h_held || h_fire))
          state_next = SEND_H;
      end
      SEND_H: begin
        h_row_out   = h_reg;
        h_row_valid = 1'b1;
        state_next  = SEND_A;
      end
      SEND_A: begin
        col_valid = 1'b1;
        last_col  = (a == A_LAST);
        for (int j = 0; j < J; j++)
          col_out[j*DATAWIDTH +: DATAWIDTH] = buffer[KW'(int'(a) * J + j)];
        if (last_col)
          state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (bus.core_done)
          state_next = LOAD;
      end
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      k          <= '0;
      a          <= '0;
      h_held     <= 1'b0;
      h_reg      <= '0;
      frames_cnt <= '0;
    end else begin
      state <= state_next;
      if (alpha_fire)
        k <= k + 1'b1;
      if (h_fire) begin
        h_held <= 1'b1;
        h_reg  <= bus.s_h_row;
      end
      if (state == SEND_A) begin
        // Column index stays on A-1 through WAIT_DONE; core_done clears it.
        if (last_col)
          frames_cnt <= frames_cnt + 16'd1;
        else
          a <= a + 1'b1;
      end
      if ((state == WAIT_DONE) && bus.core_done) begin
        k      <= '0;
        a      <= '0;
        h_held <= 1'b0;
      end
    end
  end

  // Payload storage is not reset; writes only happen on accepted beats in LOAD.
  always_ff @(posedge clk) begin
    if (alpha_fire)
      buffer[k] <= bus.s_alpha;
  end

  assign bus.s_alpha_tready     = alpha_ready;
  assign bus.s_h_tready         = h_ready;
  assign bus.H_row              = h_row_out;
  assign bus.H_row_tvalid       = h_row_valid;
  assign bus.alpha_u_col        = col_out;
  assign bus.alpha_u_col_tvalid = col_valid;
  assign bus.alpha_u_col_tlast  = last_col;
  assign bus.frames_sent        = frames_cnt;

endmodule

// File: tb/tb_alpha_col_feeder.sv
// tb/tb_alpha_col_feeder.sv - self-checking bench for alpha_col_feeder
module tb_alpha_col_feeder;
  localparam int J  = 14;
  localparam int A  = 2;
  localparam int DW = 8;
  localparam int NK = J * A;

  typedef logic [DW-1:0] frame_t [NK];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alpha_col_feeder_if #(.J(J), .DATAWIDTH(DW)) bus();
  alpha_col_feeder #(.J(J), .A(A), .DATAWIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  logic [15:0] exp_frames;

  logic [J-1:0]    h_val[$];
  int              h_cyc[$];
  logic [J*DW-1:0] col_val[$];
  logic            col_last[$];
  int              col_cyc[$];

  always @(posedge clk) cycle <= cycle + 1;

  // Output log plus idle-zero rule on every cycle.
  always @(negedge clk) begin
    if (bus.H_row_tvalid) begin
      h_val.push_back(bus.H_row);
      h_cyc.push_back(cycle);
    end else begin
      checks++;
      if (bus.H_row !== '0) begin
        errors++;
        $display("FAIL idle_h_row: got %h expected 0", bus.H_row);
      end
    end
    if (bus.alpha_u_col_tvalid) begin
      col_val.push_back(bus.alpha_u_col);
      col_last.push_back(bus.alpha_u_col_tlast);
      col_cyc.push_back(cycle);
    end else begin
      checks++;
      if (bus.alpha_u_col !== '0 || bus.alpha_u_col_tlast !== 1'b0) begin
        errors++;
        $display("FAIL idle_col: got %h tlast %b expected 0", bus.alpha_u_col, bus.alpha_u_col_tlast);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.s_alpha        = '0;
    bus.s_alpha_tvalid = 1'b0;
    bus.s_h_row        = '0;
    bus.s_h_tvalid     = 1'b0;
    bus.core_done      = 1'b0;
  endtask

  task automatic clear_logs();
    h_val.delete();
    h_cyc.delete();
    col_val.delete();
    col_last.delete();
    col_cyc.delete();
  endtask

  task automatic rand_frame(output frame_t f);
    for (int i = 0; i < NK; i++) f[i] = DW'($urandom);
  endtask

  // mode 0: back-to-back, 1: valid toggles, 2: random gaps
  task automatic send_frame(input frame_t data, input logic [J-1:0] h, input int mode,
                            input int h_delay, input int cd_at, output int last);
    int  idx;
    int  n;
    bit  h_done;
    idx = 0; n = 0; h_done = 1'b0; last = -1;
    clear_logs();
    while ((idx < NK || !h_done) && n < 1000) begin
      bus.s_alpha_tvalid = (idx < NK) && (mode == 0 || (mode == 1 && n % 2 == 0) ||
                                         (mode == 2 && $urandom % 2 == 1));
      bus.s_alpha        = (idx < NK) ? data[idx] : '0;
      bus.s_h_tvalid     = !h_done && (n >= h_delay);
      bus.s_h_row        = h;
      bus.core_done      = (n == cd_at);
      @(negedge clk);
      if (idx == NK && !h_done) begin
        checks++;
        if (bus.s_alpha_tready !== 1'b0) begin
          errors++;
          $display("FAIL alpha_ready_when_full: got %b expected 0", bus.s_alpha_tready);
        end
      end
      if (bus.s_alpha_tvalid && bus.s_alpha_tready) begin idx++; last = cycle; end
      if (bus.s_h_tvalid && bus.s_h_tready) begin h_done = 1'b1; last = cycle; end
      @(posedge clk); #1;
      n++;
    end
    idle_inputs();
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL load_timeout: stored %0d elements h %b expected %0d and 1", idx, h_done, NK);
    end
  endtask

  task automatic check_frame(input string name, input frame_t data, input logic [J-1:0] h,
                             input int last, input bit pulse_done);
    int n;
    logic [J*DW-1:0] exp_col;
    n = 0;
    while (col_val.size() < A && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL %s col_timeout: got %0d columns expected %0d", name, col_val.size(), A);
    end else begin
      checks++;
      if (bus.frames_sent !== exp_frames) begin
        errors++;
        $display("FAIL %s frames_at_tlast: got %0d expected %0d", name, bus.frames_sent, exp_frames);
      end
    end
    exp_frames = exp_frames + 16'd1;
    repeat (3) begin @(negedge clk); #1; end
    checks++;
    if (bus.frames_sent !== exp_frames) begin
      errors++;
      $display("FAIL %s frames_sent: got %0d expected %0d", name, bus.frames_sent, exp_frames);
    end
    checks++;
    if (h_val.size() != 1) begin
      errors++;
      $display("FAIL %s h_beats: got %0d expected 1", name, h_val.size());
    end else begin
      checks++;
      if (h_val[0] !== h || h_cyc[0] != last + 1) begin
        errors++;
        $display("FAIL %s h_row: got %h at %0d expected %h at %0d", name, h_val[0], h_cyc[0], h, last + 1);
      end
    end
    checks++;
    if (col_val.size() != A) begin
      errors++;
      $display("FAIL %s col_beats: got %0d expected %0d", name, col_val.size(), A);
    end else begin
      for (int c = 0; c < A; c++) begin
        for (int j = 0; j < J; j++) exp_col[j*DW +: DW] = data[c*J + j];
        checks++;
        if (col_val[c] !== exp_col || col_last[c] !== (c == A - 1) || col_cyc[c] != last + 2 + c) begin
          errors++;
          $display("FAIL %s col%0d: got %h tlast %b at %0d expected %h tlast %b at %0d", name, c,
                   col_val[c], col_last[c], col_cyc[c], exp_col, (c == A - 1), last + 2 + c);
        end
      end
    end
    if (pulse_done) begin
      @(posedge clk); #1 bus.core_done = 1'b1;
      @(posedge clk); #1 bus.core_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_alpha_tready !== 1'b1 || bus.s_h_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b %b expected 1 1", bus.s_alpha_tready, bus.s_h_tready);
    end
    checks++;
    if (bus.H_row_tvalid !== 1'b0 || bus.alpha_u_col_tvalid !== 1'b0 || bus.alpha_u_col_tlast !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b %b %b expected 0 0 0", bus.H_row_tvalid,
               bus.alpha_u_col_tvalid, bus.alpha_u_col_tlast);
    end
    checks++;
    if (bus.frames_sent !== 16'd0) begin
      errors++;
      $display("FAIL reset_frames: got %0d expected 0", bus.frames_sent);
    end
    exp_frames = 16'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    frame_t f;
    int last;
    for (int i = 0; i < NK; i++) f[i] = DW'(i);
    send_frame(f, 14'h2A5A, 0, 0, -1, last);
    check_frame("basic", f, 14'h2A5A, last, 1'b1);
  endtask

  task automatic test_h_late();
    frame_t f;
    int last;
    logic [J-1:0] h;
    rand_frame(f);
    h = J'($urandom);
    send_frame(f, h, 0, NK + 10, -1, last);
    check_frame("h_late", f, h, last, 1'b1);
  endtask

  task automatic test_gaps();
    frame_t f;
    int last;
    for (int i = 0; i < NK; i++) f[i] = DW'(i);
    send_frame(f, 14'h2A5A, 1, 0, -1, last);
    check_frame("gaps", f, 14'h2A5A, last, 1'b1);
  endtask

  task automatic test_random();
    frame_t f;
    int last;
    logic [J-1:0] h;
    for (int r = 0; r < 4; r++) begin
      rand_frame(f);
      h = J'($urandom);
      send_frame(f, h, 2, $urandom_range(60, 0), -1, last);
      check_frame("random", f, h, last, 1'b1);
    end
  endtask

  task automatic test_holdoff();
    frame_t f, g;
    int last;
    logic [J-1:0] h;
    rand_frame(f);
    rand_frame(g);
    h = J'($urandom);
    send_frame(f, h, 0, 3, -1, last);
    check_frame("holdoff1", f, h, last, 1'b0);
    bus.s_alpha_tvalid = 1'b1;
    bus.s_alpha        = ~g[0];
    bus.s_h_tvalid     = 1'b1;
    bus.s_h_row        = ~h;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.s_alpha_tready !== 1'b0 || bus.s_h_tready !== 1'b0) begin
        errors++;
        $display("FAIL holdoff_ready: got %b %b expected 0 0", bus.s_alpha_tready, bus.s_h_tready);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    bus.core_done = 1'b1;
    @(posedge clk); #1 bus.core_done = 1'b0;
    // core_done pulsed mid-load must not disturb the partially loaded frame
    send_frame(g, ~h, 0, 0, 7, last);
    check_frame("holdoff2", g, ~h, last, 1'b1);
  endtask

  task automatic test_reset_mid();
    frame_t f;
    int last;
    int n;
    rand_frame(f);
    send_frame(f, J'($urandom), 0, 0, -1, last);
    n = 0;
    while (col_val.size() < 1 && n < 50) begin @(negedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.s_alpha_tready !== 1'b1 || bus.s_h_tready !== 1'b1 || bus.frames_sent !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_state: got ready %b %b frames %0d expected 1 1 0",
               bus.s_alpha_tready, bus.s_h_tready, bus.frames_sent);
    end
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (col_val.size() != 1 || col_last[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_cols: got %0d columns expected 1 without tlast", col_val.size());
    end
    exp_frames = 16'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    frame_t f;
    int last;
    logic [J-1:0] h;
    @(negedge clk);
    force dut.frames_cnt = 16'hFFFF;
    #1 release dut.frames_cnt;
    exp_frames = 16'hFFFF;
    @(negedge clk);
    checks++;
    if (bus.frames_sent !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_preload: got %h expected ffff", bus.frames_sent);
    end
    @(posedge clk); #1;
    rand_frame(f);
    h = J'($urandom);
    send_frame(f, h, 2, 5, -1, last);
    check_frame("wrap", f, h, last, 1'b1);
  endtask

  initial begin
    idle_inputs();
    exp_frames = 16'd0;
    test_reset();
    test_basic();
    test_h_late();
    test_gaps();
    test_random();
    test_holdoff();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
